mul_error_monitor: RTL and testbench

MUL_ERROR_MONITOR -- requirements
Module: mul_error_monitor

---
 rtl/mul_error_monitor.sv | 145 ++++++++++++++
 tb/tb_mul_error_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_error_monitor.sv
// Purpose: accumulates error statistics of an approximate multiplier against the exact product.
// Latency: two-stage pipeline; a sample accepted on one edge is reflected in the statistics after the next edge.
// Backpressure: s_ready drops while a clear drains, when the sample counter is about to cap, and in HALT.
module mul_error_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_in1,
    input  logic [WIDTH-1:0]   s_in2,
    input  logic [2*WIDTH:0]   s_out,
    input  logic               s_overflow,
    output logic [CNT_W-1:0]   n_samples,
    output logic [CNT_W-1:0]   n_errors,
    output logic [CNT_W-1:0]   n_overflow,
    output logic [ACC_W-1:0]   sum_ed,
    output logic [2*WIDTH:0]   max_ed,
    output logic               sat,
    output logic               ed_sat,
    output logic               busy
);
    localparam int PW = 2*WIDTH + 1;
    // One guard bit above the wider of the accumulator and the error distance.
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_W'(1);

    typedef enum logic [1:0] {RUN, HALT, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic [PW-1:0]   exact;
    logic [PW-1:0]   ed_c;
    logic            v1;
    logic [PW-1:0]   ed1;
    logic            mis1;
    logic            ovf1;
    logic [SW-1:0]   sum_wide;

    // Exact product and absolute error distance of the incoming sample.
    always_comb begin
        exact = PW'(s_in1) * PW'(s_in2);
        ed_c  = (exact >= s_out) ? (exact - s_out) : (s_out - exact);
    end

    // Accumulator sum with a guard bit so saturation is detectable.
    always_comb begin
        sum_wide = SW'(sum_ed) + SW'(ed1);
    end

    // Next-state and ready logic; clear overrides everything, including the HALT entry.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        case (state)
            RUN: begin
                // Stop accepting one sample early when one is already in flight so the counter never wraps.
                s_ready = !rst && !clear
                          && !((n_samples == CNT_MAX_M1) && v1)
                          && (n_samples != CNT_MAX);
                if (v1 && (n_samples == CNT_MAX_M1)) begin
                    state_nxt = HALT;
                end
            end
            HALT:    state_nxt = HALT;
            DRAIN:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (clear) begin
            state_nxt = DRAIN;
        end
    end

    assign accept = s_valid && s_ready;
    assign sat    = (state == HALT);
    assign busy   = v1 || (state == DRAIN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage 1: capture per-sample error information on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            ed1  <= '0;
            mis1 <= 1'b0;
            ovf1 <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                ed1  <= ed_c;
                mis1 <= (exact != s_out);
                ovf1 <= s_overflow;
            end
        end
    end

    // Stage 2: fold the staged sample into the statistics; clear discards it and zeroes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_samples  <= '0;
            n_errors   <= '0;
            n_overflow <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            ed_sat     <= 1'b0;
        end else if (clear) begin
            n_samples  <= '0;
            n_errors   <= '0;
            n_overflow <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            ed_sat     <= 1'b0;
        end else if (v1) begin
            n_samples <= n_samples + 1'b1;
            if (mis1 && (n_errors != CNT_MAX)) begin
                n_errors <= n_errors + 1'b1;
            end
            if (ovf1 && (n_overflow != CNT_MAX)) begin
                n_overflow <= n_overflow + 1'b1;
            end
            if (sum_wide[SW-1:ACC_W] != '0) begin
                sum_ed <= '1;
                ed_sat <= 1'b1;
            end else begin
                sum_ed <= sum_wide[ACC_W-1:0];
            end
            if (ed1 > max_ed) begin
                max_ed <= ed1;
            end
        end
    end
endmodule

// File: tb/tb_mul_error_monitor.sv
// Bench for mul_error_monitor: default instance scoreboarded, plus CNT_W=3 and ACC_W=17 instances.
module tb_mul_error_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        va0 = 1'b0, va1 = 1'b0, va2 = 1'b0;
    logic [7:0]  in1 = '0, in2 = '0;
    logic [16:0] sout = '0;
    logic        sovf = 1'b0;

    logic        rdy0, sat0, esat0, busy0;
    logic [15:0] ns0, ne0, no0;
    logic [39:0] sum0;
    logic [16:0] max0;

    logic        rdy1, sat1, esat1, busy1;
    logic [2:0]  ns1, ne1, no1;
    logic [39:0] sum1;
    logic [16:0] max1;

    logic        rdy2, sat2, esat2, busy2;
    logic [15:0] ns2, ne2, no2;
    logic [16:0] sum2;
    logic [16:0] max2;

    int checks = 0;
    int errors = 0;
    int acc_cnt1 = 0;

    typedef struct {
        logic [15:0] ns;
        logic [15:0] ne;
        logic [15:0] no;
        logic [39:0] sum;
        logic [16:0] mx;
    } snap_t;

    snap_t       q[$];
    logic [15:0] m_ns = '0, m_ne = '0, m_no = '0;
    logic [39:0] m_sum = '0;
    logic [16:0] m_mx = '0;
    logic        p1 = 1'b0, p2 = 1'b0;

    always #5 clk = ~clk;

    mul_error_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(40)) d0 (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(va0), .s_ready(rdy0),
        .s_in1(in1), .s_in2(in2), .s_out(sout), .s_overflow(sovf),
        .n_samples(ns0), .n_errors(ne0), .n_overflow(no0), .sum_ed(sum0),
        .max_ed(max0), .sat(sat0), .ed_sat(esat0), .busy(busy0));

    mul_error_monitor #(.WIDTH(8), .CNT_W(3), .ACC_W(40)) d1 (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(va1), .s_ready(rdy1),
        .s_in1(in1), .s_in2(in2), .s_out(sout), .s_overflow(sovf),
        .n_samples(ns1), .n_errors(ne1), .n_overflow(no1), .sum_ed(sum1),
        .max_ed(max1), .sat(sat1), .ed_sat(esat1), .busy(busy1));

    mul_error_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(17)) d2 (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(va2), .s_ready(rdy2),
        .s_in1(in1), .s_in2(in2), .s_out(sout), .s_overflow(sovf),
        .n_samples(ns2), .n_errors(ne2), .n_overflow(no2), .sum_ed(sum2),
        .max_ed(max2), .sat(sat2), .ed_sat(esat2), .busy(busy2));

    task automatic set_in(input int a, input int b, input int o, input bit ovf);
        in1  = 8'(a);
        in2  = 8'(b);
        sout = 17'(o);
        sovf = ovf;
    endtask

    task automatic model_reset();
        q.delete();
        m_ns = '0; m_ne = '0; m_no = '0; m_sum = '0; m_mx = '0;
        p1 = 1'b0; p2 = 1'b0;
    endtask

    // One clock: compare scoreboard entries due now, record acceptances, advance to just after the edge.
    task automatic tick();
        snap_t       s;
        logic        acc;
        longint      ex, ed;
        logic [40:0] t;
        @(negedge clk);
        if (p2) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty got 0 entries want 1");
            end else begin
                s = q.pop_front();
                checks++;
                if (ns0 !== s.ns) begin errors++; $display("FAIL sb_n_samples got %0d want %0d", ns0, s.ns); end
                checks++;
                if (ne0 !== s.ne) begin errors++; $display("FAIL sb_n_errors got %0d want %0d", ne0, s.ne); end
                checks++;
                if (no0 !== s.no) begin errors++; $display("FAIL sb_n_overflow got %0d want %0d", no0, s.no); end
                checks++;
                if (sum0 !== s.sum) begin errors++; $display("FAIL sb_sum_ed got %0d want %0d", sum0, s.sum); end
                checks++;
                if (max0 !== s.mx) begin errors++; $display("FAIL sb_max_ed got %0d want %0d", max0, s.mx); end
            end
        end
        if (clear) model_reset();
        acc = va0 && rdy0;
        if (acc) begin
            ex = longint'(in1) * longint'(in2);
            ed = (ex >= longint'(sout)) ? ex - longint'(sout) : longint'(sout) - ex;
            m_ns = m_ns + 16'd1;
            if (ex != longint'(sout)) m_ne = m_ne + 16'd1;
            if (sovf) m_no = m_no + 16'd1;
            t = {1'b0, m_sum} + 41'(ed);
            m_sum = t[40] ? '1 : t[39:0];
            if (17'(ed) > m_mx) m_mx = 17'(ed);
            s.ns = m_ns; s.ne = m_ne; s.no = m_no; s.sum = m_sum; s.mx = m_mx;
            q.push_back(s);
        end
        if (va1 && rdy1) acc_cnt1++;
        p2 = p1;
        p1 = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", rdy0); end
        checks++; if (ns0 !== 16'd0) begin errors++; $display("FAIL rst_n_samples got %0d want 0", ns0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy0); end
        checks++; if (sat0 !== 1'b0 || esat0 !== 1'b0) begin errors++; $display("FAIL rst_sat got %b%b want 00", sat0, esat0); end
        checks++; if (sum0 !== 40'd0 || max0 !== 17'd0) begin errors++; $display("FAIL rst_stats got %0d/%0d want 0/0", sum0, max0); end
        rst = 1'b0;
        tick();
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", rdy0); end
    endtask

    task automatic test_exact();
        set_in(12, 10, 120, 1'b0);
        va0 = 1'b1;
        tick();
        va0 = 1'b0;
        tick();
        checks++; if (ns0 !== 16'd1) begin errors++; $display("FAIL exact_n_samples got %0d want 1", ns0); end
        checks++; if (ne0 !== 16'd0) begin errors++; $display("FAIL exact_n_errors got %0d want 0", ne0); end
        checks++; if (sum0 !== 40'd0 || max0 !== 17'd0) begin errors++; $display("FAIL exact_ed got %0d/%0d want 0/0", sum0, max0); end
        tick();
    endtask

    task automatic test_back_to_back();
        int a[3] = '{12, 12, 255};
        int b[3] = '{10, 10, 255};
        int o[3] = '{118, 130, 0};
        for (int i = 0; i < 3; i++) begin
            set_in(a[i], b[i], o[i], i == 2);
            va0 = 1'b1;
            checks++;
            if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, rdy0); end
            tick();
        end
        va0 = 1'b0;
        sovf = 1'b0;
        tick();
        tick();
        checks++; if (ne0 !== 16'd3) begin errors++; $display("FAIL b2b_n_errors got %0d want 3", ne0); end
        checks++; if (sum0 !== 40'd65037) begin errors++; $display("FAIL b2b_sum_ed got %0d want 65037", sum0); end
        checks++; if (max0 !== 17'd65025) begin errors++; $display("FAIL b2b_max_ed got %0d want 65025", max0); end
        checks++; if (ns0 !== 16'd4 || no0 !== 16'd1) begin errors++; $display("FAIL b2b_counts got %0d/%0d want 4/1", ns0, no0); end
    endtask

    task automatic test_clear_inflight();
        set_in(12, 10, 125, 1'b0);
        va0 = 1'b1;
        tick();
        va0 = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        checks++; if (rdy0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL clr_drain got rdy=%b busy=%b want rdy=0 busy=1", rdy0, busy0); end
        tick();
        checks++; if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL clr_run got rdy=%b busy=%b want rdy=1 busy=0", rdy0, busy0); end
        checks++; if (ns0 !== 16'd0 || ne0 !== 16'd0 || no0 !== 16'd0) begin errors++; $display("FAIL clr_counts got %0d/%0d/%0d want 0/0/0", ns0, ne0, no0); end
        checks++; if (sum0 !== 40'd0 || max0 !== 17'd0) begin errors++; $display("FAIL clr_ed got %0d/%0d want 0/0", sum0, max0); end
        // Clear held for two cycles keeps the monitor in DRAIN one cycle longer.
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        #1;
        checks++; if (rdy0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL clr_extend got rdy=%b busy=%b want rdy=0 busy=1", rdy0, busy0); end
        tick();
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL clr_extend_exit got rdy=%b want 1", rdy0); end
    endtask

    task automatic test_reset_mid();
        set_in(12, 10, 100, 1'b0);
        va0 = 1'b1;
        tick();
        set_in(7, 7, 40, 1'b0);
        tick();
        va0 = 1'b0;
        checks++; if (ns0 !== 16'd1 || busy0 !== 1'b1) begin errors++; $display("FAIL rmid_pre got ns=%0d busy=%b want ns=1 busy=1", ns0, busy0); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ns0 !== 16'd0 || sum0 !== 40'd0 || max0 !== 17'd0) begin errors++; $display("FAIL rmid_async got %0d/%0d/%0d want 0/0/0", ns0, sum0, max0); end
        checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy got busy=%b rdy=%b want 0/0", busy0, rdy0); end
        model_reset();
        rst = 1'b0;
        set_in(3, 4, 12, 1'b0);
        va0 = 1'b1;
        tick();
        va0 = 1'b0;
        tick();
        checks++; if (ns0 !== 16'd1 || ne0 !== 16'd0) begin errors++; $display("FAIL rmid_after got %0d/%0d want 1/0", ns0, ne0); end
        tick();
    endtask

    task automatic test_saturation();
        acc_cnt1 = 0;
        set_in(5, 5, 20, 1'b0);
        va1 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL sat_ready got %b want 0", rdy1); end
        va1 = 1'b0;
        tick();
        tick();
        checks++; if (acc_cnt1 != 7) begin errors++; $display("FAIL sat_accepted got %0d want 7", acc_cnt1); end
        checks++; if (ns1 !== 3'd7) begin errors++; $display("FAIL sat_n_samples got %0d want 7", ns1); end
        checks++; if (sat1 !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", sat1); end
        checks++; if (ne1 !== 3'd7) begin errors++; $display("FAIL sat_n_errors got %0d want 7", ne1); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        checks++; if (sat1 !== 1'b0 || ns1 !== 3'd0 || rdy1 !== 1'b1) begin errors++; $display("FAIL sat_clear got sat=%b ns=%0d rdy=%b want 0/0/1", sat1, ns1, rdy1); end
    endtask

    task automatic test_acc_sat();
        set_in(255, 255, 0, 1'b0);
        va2 = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (sum2 !== 17'd130050 || esat2 !== 1'b0) begin errors++; $display("FAIL accsat_mid got %0d/%b want 130050/0", sum2, esat2); end
        tick();
        va2 = 1'b0;
        tick();
        tick();
        checks++; if (sum2 !== 17'd131071) begin errors++; $display("FAIL accsat_sum got %0d want 131071", sum2); end
        checks++; if (esat2 !== 1'b1) begin errors++; $display("FAIL accsat_flag got %b want 1", esat2); end
        checks++; if (ns2 !== 16'd4 || max2 !== 17'd65025) begin errors++; $display("FAIL accsat_counts got %0d/%0d want 4/65025", ns2, max2); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_back_to_back();
        test_clear_inflight();
        test_reset_mid();
        test_saturation();
        test_acc_sat();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d entries want 0", q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
